// File: rtl/signal_gen_pkg.sv
// Shared definitions for the multi-voice signal generator: register map
// addresses, voice mode encodings and the noise LFSR seed.
package signal_gen_pkg;

  // Register map, selected by the 3-bit address bus.
  localparam logic [2:0] AddrSel   = 3'd0;
  localparam logic [2:0] AddrPerLo = 3'd1;
  localparam logic [2:0] AddrPerHi = 3'd2;
  localparam logic [2:0] AddrVol   = 3'd3;
  localparam logic [2:0] AddrMode  = 3'd4;
  localparam logic [2:0] AddrCtrl  = 3'd5;

  typedef enum logic [1:0] {
    ModeOff     = 2'b00,
    ModeSquare  = 2'b01,
    ModePulse25 = 2'b10,
    ModeNoise   = 2'b11
  } mode_e;

  // Noise polynomial is x^W + x^(W-1) + 1: feedback taps are the two MSBs.
  localparam int unsigned LfsrSeed = 1;

endpackage

// File: rtl/tone_voice.sv
// One tone voice: period/volume/mode registers, tick-driven period counter
// and 2-bit phase. Produces its gated volume contribution and a wrap pulse.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   enable                  master enable; 0 holds cnt/phase at 0 and mutes
//   tick                    prescaled voice tick (already gated by enable)
//   sync                    one-shot clear of cnt/phase, overrides tick
//   noise_bit               shared LFSR output bit
//   wr_period/period_new    period write
//   wr_volume/volume_new    volume write
//   wr_mode/mode_new        mode write
//   level                   volume when the voice is high, else 0
//   wrap                    pulses on the tick where the counter wraps
module tone_voice
  import signal_gen_pkg::*;
#(
  parameter int unsigned PERIOD_W = 10,
  parameter int unsigned VOL_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                tick,
  input  logic                sync,
  input  logic                noise_bit,
  input  logic                wr_period,
  input  logic [PERIOD_W-1:0] period_new,
  input  logic                wr_volume,
  input  logic [VOL_W-1:0]    volume_new,
  input  logic                wr_mode,
  input  mode_e               mode_new,
  output logic [VOL_W-1:0]    level,
  output logic                wrap
);

  logic [PERIOD_W-1:0] period_q, cnt_q, cnt_d;
  logic [VOL_W-1:0]    volume_q;
  mode_e               mode_q;
  logic [1:0]          phase_q, phase_d;
  logic                high;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      volume_q <= '0;
      mode_q   <= ModeOff;
      cnt_q    <= '0;
      phase_q  <= '0;
    end else begin
      if (wr_period) period_q <= period_new;
      if (wr_volume) volume_q <= volume_new;
      if (wr_mode)   mode_q   <= mode_new;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Compare uses the registered period, so a same-cycle period write only
  // takes effect on the following tick. ">=" lets a shrunk period wrap at once.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    wrap    = 1'b0;
    if (!enable || sync) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (tick) begin
      if (cnt_q >= period_q) begin
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
        wrap    = 1'b1;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_comb begin
    high = 1'b0;
    unique case (mode_q)
      ModeOff:     high = 1'b0;
      ModeSquare:  high = phase_q[0];
      ModePulse25: high = (phase_q == 2'd3);
      ModeNoise:   high = noise_bit;
    endcase
  end

  assign level = (enable && high) ? volume_q : '0;

endmodule

// File: rtl/multi_voice_signal_gen.sv
// Multi-voice tone generator with 1-bit sigma-delta output.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   write_strobe   asynchronous pad strobe; each rising edge commits a write
//   address, data  register address/data, stable around the strobe
//   signal_out     sigma-delta audio bit
//   debug          {mix_sum[4:0], voice_sel[1:0]}
module multi_voice_signal_gen
  import signal_gen_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PERIOD_W   = 10,
  parameter int unsigned VOL_W      = 3,
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned LFSR_W     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write_strobe,
  input  logic [2:0] address,
  input  logic [4:0] data,
  output logic       signal_out,
  output logic [6:0] debug
);

  localparam int unsigned SUM_W = $clog2(NUM_VOICES * (2 ** VOL_W - 1) + 1);
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic              strobe_meta_q, strobe_sync_q, strobe_prev_q;
  logic              wr_en, sync_all, tick;
  logic [1:0]        voice_sel_q;
  logic [4:0]        staging_q;
  logic              enable_q;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [SUM_W:0]    acc_q, acc_d;
  logic [SUM_W-1:0]  mix_sum;
  logic [VOL_W-1:0]  level [NUM_VOICES];
  logic [NUM_VOICES-1:0] wrap;

  // Synchroniser resets high so a strobe already high at release is not
  // mistaken for an edge; only a rise after release commits a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_meta_q <= 1'b1;
      strobe_sync_q <= 1'b1;
      strobe_prev_q <= 1'b1;
    end else begin
      strobe_meta_q <= write_strobe;
      strobe_sync_q <= strobe_meta_q;
      strobe_prev_q <= strobe_sync_q;
    end
  end

  assign wr_en    = strobe_sync_q & ~strobe_prev_q;
  assign sync_all = wr_en && (address == AddrCtrl) && data[1];
  assign tick     = enable_q && (presc_q == PRE_W'(PRESCALE - 1));

  always_comb begin
    presc_d = '0;
    if (enable_q && !tick) presc_d = presc_q + PRE_W'(1);
  end

  // Select compares the whole data field so out-of-range values are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voice_sel_q <= '0;
      staging_q   <= '0;
      enable_q    <= 1'b0;
      presc_q     <= '0;
      lfsr_q      <= LFSR_W'(LfsrSeed);
      acc_q       <= '0;
    end else begin
      if (wr_en && address == AddrSel && data < 5'(NUM_VOICES)) voice_sel_q <= data[1:0];
      if (wr_en && address == AddrPerLo) staging_q <= data;
      if (wr_en && address == AddrCtrl)  enable_q  <= data[0];
      presc_q <= presc_d;
      lfsr_q  <= lfsr_d;
      acc_q   <= acc_d;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic hit;
    assign hit = wr_en && (voice_sel_q == 2'(v));
    tone_voice #(
      .PERIOD_W (PERIOD_W),
      .VOL_W    (VOL_W)
    ) u_voice (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable_q),
      .tick       (tick),
      .sync       (sync_all),
      .noise_bit  (lfsr_q[0]),
      .wr_period  (hit && address == AddrPerHi),
      .period_new (PERIOD_W'({data, staging_q})),
      .wr_volume  (hit && address == AddrVol),
      .volume_new (data[VOL_W-1:0]),
      .wr_mode    (hit && address == AddrMode),
      .mode_new   (mode_e'(data[1:0])),
      .level      (level[v]),
      .wrap       (wrap[v])
    );
  end

  // Shared LFSR advances once for every voice that wraps this cycle.
  always_comb begin
    lfsr_d = lfsr_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (wrap[i]) lfsr_d = {lfsr_d[LFSR_W-2:0], lfsr_d[LFSR_W-1] ^ lfsr_d[LFSR_W-2]};
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) mix_sum = mix_sum + SUM_W'(level[i]);
  end

  // First-order sigma-delta: the carry out of the SUM_W-bit accumulator is the output.
  always_comb begin
    acc_d = '0;
    if (enable_q) acc_d = {1'b0, acc_q[SUM_W-1:0]} + {1'b0, mix_sum};
  end

  assign signal_out = acc_q[SUM_W];
  assign debug      = {5'(mix_sum), voice_sel_q};

endmodule

// File: tb/tb_multi_voice_signal_gen.sv
// Scoreboard bench: a behavioural model pushes the expected outputs after
// every clock edge; a monitor pops and compares them on the falling edge.
module tb_multi_voice_signal_gen;

  localparam int NV   = 4;
  localparam int P    = 16;
  localparam int SUMW = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       write_strobe = 1'b0;
  logic [2:0] address = '0;
  logic [4:0] data = '0;
  logic       signal_out;
  logic [6:0] debug;

  multi_voice_signal_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_strobe (write_strobe),
    .address      (address),
    .data         (data),
    .signal_out   (signal_out),
    .debug        (debug)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct { int cyc; int addr; int dat; } wr_t;
  typedef struct { int sout; int dbg; } exp_t;
  wr_t  pend[$];
  exp_t exp_q[$];
  int   cyc = 0;
  bit   model_on = 0;

  int m_en, m_sel, m_stg, m_presc, m_lfsr, m_acc;
  int m_per[NV], m_vol[NV], m_mode[NV], m_cnt[NV], m_ph[NV];

  function automatic bit m_high(int v);
    case (m_mode[v])
      1: return (m_ph[v] % 2) == 1;
      2: return m_ph[v] == 3;
      3: return (m_lfsr % 2) == 1;
      default: return 0;
    endcase
  endfunction

  function automatic int m_mix();
    int s = 0;
    for (int v = 0; v < NV; v++) if (m_en != 0 && m_high(v)) s += m_vol[v];
    return s;
  endfunction

  task automatic model_reset();
    m_en = 0; m_sel = 0; m_stg = 0; m_presc = 0; m_lfsr = 1; m_acc = 0;
    for (int v = 0; v < NV; v++) begin
      m_per[v] = 0; m_vol[v] = 0; m_mode[v] = 0; m_cnt[v] = 0; m_ph[v] = 0;
    end
  endtask

  // Reference model: state after each rising edge, from the register-level rules.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (model_on) begin
        int   mix_old, nwrap, wa, wd;
        bit   tick, w, sync;
        exp_t e;
        mix_old = m_mix();
        tick = (m_en != 0) && (m_presc == P - 1);
        w = 0; wa = 0; wd = 0;
        if (pend.size() > 0 && pend[0].cyc == cyc) begin
          w = 1; wa = pend[0].addr; wd = pend[0].dat;
          void'(pend.pop_front());
        end
        sync = w && wa == 5 && ((wd / 2) % 2 == 1);
        m_presc = (m_en == 0 || tick) ? 0 : m_presc + 1;
        nwrap = 0;
        for (int v = 0; v < NV; v++) begin
          if (m_en == 0 || sync) begin
            m_cnt[v] = 0; m_ph[v] = 0;
          end else if (tick) begin
            if (m_cnt[v] >= m_per[v]) begin
              m_cnt[v] = 0; m_ph[v] = (m_ph[v] + 1) % 4; nwrap++;
            end else m_cnt[v]++;
          end
        end
        repeat (nwrap) begin
          int fb;
          fb = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
          m_lfsr = ((m_lfsr << 1) | fb) & 32'h7fff;
        end
        m_acc = (m_en != 0) ? (m_acc % (1 << SUMW)) + mix_old : 0;
        if (w) begin
          case (wa)
            0: if (wd < NV) m_sel = wd;
            1: m_stg = wd;
            2: m_per[m_sel] = wd * 32 + m_stg;
            3: m_vol[m_sel] = wd % 8;
            4: m_mode[m_sel] = wd % 4;
            5: m_en = wd % 2;
            default: ;
          endcase
        end
        e.sout = m_acc >> SUMW;
        e.dbg  = ((m_mix() % 32) << 2) | m_sel;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares the DUT against the oldest expected entry each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (int'(signal_out) != e.sout) begin
          bad++;
          $display("FAIL signal_out cyc=%0d got=%0d want=%0d", cyc, signal_out, e.sout);
        end
        total++;
        if (int'(debug) != e.dbg) begin
          bad++;
          $display("FAIL debug cyc=%0d got=%0h want=%0h", cyc, debug, e.dbg);
        end
      end
    end
  end

  // Strobe rises after a falling edge; the write commits on the third rising edge.
  task automatic wr(input int a, input int d);
    wr_t t;
    @(negedge clk);
    address = 3'(a); data = 5'(d); write_strobe = 1'b1;
    t.cyc = cyc + 3; t.addr = a; t.dat = d;
    pend.push_back(t);
    repeat (4) @(negedge clk);
    write_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic voice_setup(input int v, input int mode, input int per, input int vol);
    wr(0, v); wr(4, mode); wr(1, per % 32); wr(2, per / 32); wr(3, vol);
  endtask

  task automatic budget_fail(input string what);
    total++; bad++;
    $display("FAIL %s got=timeout want=condition", what);
  endtask

  task automatic do_reset(input bit check_now);
    @(negedge clk);
    #2;
    model_on = 0;
    rst_n = 1'b0;
    write_strobe = 1'b0;
    #1;
    if (check_now) begin
      total++;
      if (signal_out !== 1'b0) begin
        bad++; $display("FAIL async_reset_out got=%0b want=0", signal_out);
      end
      total++;
      if (debug !== 7'd0) begin
        bad++; $display("FAIL async_reset_debug got=%0h want=0", debug);
      end
    end
    exp_q.delete(); pend.delete(); model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_on = 1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit found;
    model_reset();
    do_reset(1'b1);
    repeat (1000) @(negedge clk);

    // Single square voice, then a full four-voice chord at maximum sum.
    voice_setup(0, 1, 3, 7);
    wr(5, 1);
    repeat (300) @(negedge clk);
    voice_setup(1, 1, 3, 7);
    voice_setup(2, 2, 3, 7);
    voice_setup(3, 2, 3, 7);
    wr(5, 3);
    repeat (400) @(negedge clk);

    // Staged period: PER_LO alone changes nothing, PER_HI commits 37.
    wr(0, 0);
    wr(1, 5);
    repeat (100) @(negedge clk);
    wr(2, 1);
    repeat (1500) @(negedge clk);

    // Shrink the period while the counter sits above it.
    wr(1, 2);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (m_cnt[0] == 8) found = 1;
    end
    if (!found) budget_fail("wait_cnt8");
    wr(2, 0);
    repeat (200) @(negedge clk);

    // Period write committing on the same edge as a tick.
    wr(1, 5);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (m_presc == 12) found = 1;
    end
    if (!found) budget_fail("wait_tick_align");
    wr(2, 0);
    repeat (200) @(negedge clk);

    // Out-of-range and in-range voice select, reserved addresses, noise voice.
    wr(0, 5);
    wr(0, 2);
    wr(6, 31);
    wr(7, 31);
    voice_setup(1, 3, 0, 5);
    repeat (400) @(negedge clk);

    // Random register traffic with mostly small periods and enable kept on.
    for (int i = 0; i < 150; i++) begin
      int a, d;
      a = $urandom_range(0, 7);
      d = $urandom_range(0, 31);
      if (a == 5) d = d | 1;
      if (a == 2) d = $urandom_range(0, 1);
      wr(a, d);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end

    // Busy chord, then reset in the middle of it.
    for (int v = 0; v < NV; v++) voice_setup(v, 1, 0, 7);
    wr(5, 1);
    repeat (123) @(negedge clk);
    do_reset(1'b1);
    repeat (50) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
